// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO; frames go out back-to-back while data is queued.
// Define UART_TX_PARITY_EN to compile in the parity bit; otherwise the parity input is ignored.
module uart_tx_fifo #(
    parameter  int DATA_BITS = 8,
    parameter  int DEPTH     = 16,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          period,
    input  logic [1:0]           parity,
    input  logic                 stop2,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 txd,
    output logic                 tx_avai,
    output logic                 tx_busy,
    output logic [ADDR_W:0]      tx_count,
    output logic                 tx_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [ADDR_W:0] FULL     = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 ovf_q, ovf_d;
    state_t               state_q, state_d;
    logic [15:0]          baud_q, baud_d, term;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 txd_q, txd_d;
    logic                 push, pop, tick, full, nonempty;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
`else
    logic                 unused_parity;
    assign unused_parity = ^parity;
`endif

    always_comb begin
        full     = (count_q == FULL);
        nonempty = (count_q != '0);
        push     = tx_start && !full;
        term     = (period == 16'd0) ? 16'd0 : period - 16'd1;
        tick     = (baud_q == term);
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = tick ? 16'd0 : baud_q + 16'd1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                if (nonempty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
                        stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if (nonempty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame settings are captured at pop so mid-frame changes wait for the next frame
        if (pop) begin
            shreg_d = mem_q[rd_ptr_q];
            stop2_d = stop2;
            baud_d  = 16'd0;
`ifdef UART_TX_PARITY_EN
            par_en_d  = ^parity;
            par_bit_d = (parity == 2'b10) ^ (^mem_q[rd_ptr_q]);
`endif
        end

        unique case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_bit_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        count_d  = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
        ovf_d    = ovf_q | (tx_start & full);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= 16'd0;
            bit_q      <= 3'd0;
            shreg_q    <= '0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign txd      = txd_q;
    assign tx_avai  = !full;
    assign tx_busy  = (state_q != S_IDLE) || nonempty;
    assign tx_count = count_q;
    assign tx_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4): single frame, parity, back-to-back,
// overflow, period 0 and reset mid-frame.
module tb_uart_tx_fifo;

    localparam int DB  = 8;
    localparam int DEP = 4;
    localparam int AW  = $clog2(DEP);

    logic          clk;
    logic          rst;
    logic [15:0]   period;
    logic [1:0]    parity;
    logic          stop2;
    logic          tx_start;
    logic [DB-1:0] tx_data;
    logic          txd;
    logic          tx_avai;
    logic          tx_busy;
    logic [AW:0]   tx_count;
    logic          tx_ovf;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.DATA_BITS(DB), .DEPTH(DEP)) dut (
        .clk      (clk),
        .rst      (rst),
        .period   (period),
        .parity   (parity),
        .stop2    (stop2),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .txd      (txd),
        .tx_avai  (tx_avai),
        .tx_busy  (tx_busy),
        .tx_count (tx_count),
        .tx_ovf   (tx_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks txd every cycle from cycle 'skip' to the last cycle of the frame
    task automatic check_frame(input string tag, input logic [15:0] fb,
                               input int nbits, input int per, input int skip);
        for (int i = skip; i < nbits * per; i++) begin
            chk(tag, 32'(txd), 32'(fb[i / per]));
            if (i != nbits * per - 1) step();
        end
    endtask

    initial begin
        int falls;
        int cyc;
        int bad;
        logic prev;

        rst = 1'b1; period = 16'd4; parity = 2'b00; stop2 = 1'b0;
        tx_start = 1'b0; tx_data = '0;
        step();
        step();
        chk("rst_txd",   32'(txd), 1);
        chk("rst_count", 32'(tx_count), 0);
        chk("rst_avai",  32'(tx_avai), 1);
        chk("rst_busy",  32'(tx_busy), 0);
        chk("rst_ovf",   32'(tx_ovf), 0);
        rst = 1'b0;

        // single frame 8N1, period 4, 0x55
        tx_data = 8'h55; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        chk("t1_count_wr", 32'(tx_count), 1);
        chk("t1_txd_idle", 32'(txd), 1);
        step();
        chk("t1_count_pop", 32'(tx_count), 0);
        chk("t1_busy", 32'(tx_busy), 1);
        check_frame("t1_frame", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 4, 0);
        chk("t1_busy_last", 32'(tx_busy), 1);
        step();
        chk("t1_busy_drop", 32'(tx_busy), 0);
        chk("t1_txd_end", 32'(txd), 1);

        // period 0 behaves as 1
        period = 16'd0;
        tx_data = 8'hA5; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        check_frame("p0_frame", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1, 0);
        step();
        chk("p0_busy_drop", 32'(tx_busy), 0);

        period = 16'd2;
`ifdef UART_TX_PARITY_EN
        parity = 2'b01;
        tx_data = 8'h07; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        parity = 2'b00;
        check_frame("par_even", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 2, 0);
        step();
        chk("par_even_busy", 32'(tx_busy), 0);
        parity = 2'b10;
        tx_data = 8'h07; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        check_frame("par_odd", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 2, 0);
        step();
        chk("par_odd_busy", 32'(tx_busy), 0);
`else
        parity = 2'b01;
        tx_data = 8'h07; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        step();
        check_frame("nopar_frame", {6'b0, 1'b1, 8'h07, 1'b0}, 10, 2, 0);
        step();
        chk("nopar_busy", 32'(tx_busy), 0);
`endif
        parity = 2'b00;

        // back-to-back, period 1, two stop bits
        period = 16'd1; stop2 = 1'b1;
        tx_data = 8'h01; tx_start = 1'b1;
        step();
        chk("b2b_cnt_e1", 32'(tx_count), 1);
        tx_data = 8'h02;
        step();
        chk("b2b_cnt_e2", 32'(tx_count), 1);
        chk("b2b_start1", 32'(txd), 0);
        tx_data = 8'h03;
        step();
        tx_start = 1'b0;
        chk("b2b_cnt_e3", 32'(tx_count), 2);
        check_frame("b2b_f1", {5'b0, 2'b11, 8'h01, 1'b0}, 11, 1, 1);
        chk("b2b_cnt_f1end", 32'(tx_count), 2);
        step();
        chk("b2b_cnt_f2", 32'(tx_count), 1);
        check_frame("b2b_f2", {5'b0, 2'b11, 8'h02, 1'b0}, 11, 1, 0);
        step();
        chk("b2b_cnt_f3", 32'(tx_count), 0);
        check_frame("b2b_f3", {5'b0, 2'b11, 8'h03, 1'b0}, 11, 1, 0);
        chk("b2b_busy_last", 32'(tx_busy), 1);
        step();
        chk("b2b_busy_drop", 32'(tx_busy), 0);
        chk("b2b_txd_end", 32'(txd), 1);
        stop2 = 1'b0;

        // overflow: 6 writes into a 4-deep FIFO
        period = 16'd100;
        tx_data = 8'hFF; tx_start = 1'b1;
        falls = 0;
        prev = txd;
        for (int i = 0; i < 6; i++) begin
            step();
            if (prev && !txd) falls++;
            prev = txd;
            if (i == 4) begin
                chk("ovf_cnt_full", 32'(tx_count), 4);
                chk("ovf_avai", 32'(tx_avai), 0);
                chk("ovf_flag_pre", 32'(tx_ovf), 0);
            end
        end
        tx_start = 1'b0;
        chk("ovf_flag", 32'(tx_ovf), 1);
        chk("ovf_cnt_after", 32'(tx_count), 4);
        cyc = 0;
        while (tx_busy && cyc < 8000) begin
            step();
            cyc++;
            if (prev && !txd) falls++;
            prev = txd;
        end
        chk("ovf_timeout", 32'(cyc < 8000), 1);
        chk("ovf_frames", 32'(falls), 5);
        chk("ovf_sticky", 32'(tx_ovf), 1);

        // reset mid-frame with 3 bytes queued
        period = 16'd4;
        tx_data = 8'h3C; tx_start = 1'b1;
        repeat (4) step();
        tx_start = 1'b0;
        chk("rmf_queued", 32'(tx_count), 3);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmf_txd", 32'(txd), 1);
        chk("rmf_count", 32'(tx_count), 0);
        chk("rmf_busy", 32'(tx_busy), 0);
        chk("rmf_ovf", 32'(tx_ovf), 0);
        bad = 0;
        repeat (200) begin
            step();
            if (!txd || tx_busy) bad++;
        end
        chk("rmf_quiet", 32'(bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
